// File: rtl/ddram_pkg.sv
// Shared DDRAM port types for the framebuffer channels.
package ddram_pkg;

  localparam logic [3:0] DDRAM_REGION = 4'b0011;

  typedef logic [63:0] ddr_word_t;
  typedef logic [24:0] ddr_addr_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN
  } rd_state_e;

endpackage

// File: rtl/ddram_fb_reader_fifo.sv
// Synchronous word FIFO with show-ahead output and single-cycle flush.
module fb_word_fifo
  import ddram_pkg::*;
#(
  parameter int unsigned DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  ddr_word_t                din,
  output ddr_word_t                dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned AW = $clog2(DEPTH);

  ddr_word_t        mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && full && !pop));
  end

endmodule

// File: rtl/ddram_fb_reader.sv
// Framebuffer scan-out reader: burst-reads 64-bit words from DDRAM and
// unpacks them into 16-bit pixels on request.
module ddram_fb_reader
  import ddram_pkg::*;
#(
  parameter logic [26:0] FB_BASE     = 27'h0200000,
  parameter int unsigned FRAME_WORDS = 9600,
  parameter int unsigned BURST       = 8,
  parameter int unsigned FIFO_DEPTH  = 32
) (
  input  logic        DDRAM_CLK,
  input  logic        reset,
  input  logic        DDRAM_BUSY,
  output logic [7:0]  DDRAM_BURSTCNT,
  output logic [28:0] DDRAM_ADDR,
  input  logic [63:0] DDRAM_DOUT,
  input  logic        DDRAM_DOUT_READY,
  output logic        DDRAM_RD,
  output logic        DDRAM_WE,
  output logic [7:0]  DDRAM_BE,
  output logic [63:0] DDRAM_DIN,
  input  logic        frame_start,
  input  logic        pix_req,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  output logic        underflow
);

  localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;
  localparam ddr_addr_t   BASE_WORD = {1'b0, FB_BASE[26:3]};

  rd_state_e  state, state_n;
  ddr_addr_t  word_ptr;
  logic [7:0] beat_cnt;
  logic [7:0] cur_len;
  logic [7:0] burst_len;
  logic       pend;
  logic [1:0] sub;

  logic [31:0] remaining;
  logic [31:0] free_slots;
  logic        can_req;
  logic        last_beat;

  logic        rd, accept, push, flush, beat, adv, set_pend;
  logic        avail, pop;

  ddr_word_t       fifo_dout;
  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic            fifo_full;

  fb_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (DDRAM_CLK),
    .rst   (reset),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (DDRAM_DOUT),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign remaining  = FRAME_WORDS - 32'(word_ptr);
  assign burst_len  = (remaining < BURST) ? remaining[7:0] : 8'(BURST);
  assign free_slots = FIFO_DEPTH - 32'(fifo_count);
  assign can_req    = (32'(word_ptr) < FRAME_WORDS) && (free_slots >= BURST) && !fifo_full;
  assign last_beat  = ((beat_cnt + 8'd1) == cur_len);

  // An accepted command cannot be withdrawn, so a restart waits for its
  // beats (DRAIN, or pend while still in REQ) before flushing.
  always_comb begin
    state_n  = state;
    rd       = 1'b0;
    accept   = 1'b0;
    push     = 1'b0;
    flush    = 1'b0;
    beat     = 1'b0;
    adv      = 1'b0;
    set_pend = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start)  flush   = 1'b1;
        else if (can_req) state_n = REQ;
      end
      REQ: begin
        rd = 1'b1;
        if (!DDRAM_BUSY) begin
          accept  = 1'b1;
          state_n = (pend || frame_start) ? DRAIN : WAIT;
        end else if (frame_start) begin
          set_pend = 1'b1;
        end
      end
      WAIT: begin
        if (DDRAM_DOUT_READY) begin
          beat = 1'b1;
          push = !frame_start;
          if (last_beat) begin
            state_n = IDLE;
            if (frame_start) flush = 1'b1;
            else             adv   = 1'b1;
          end else if (frame_start) begin
            state_n = DRAIN;
          end
        end else if (frame_start) begin
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (DDRAM_DOUT_READY) begin
          beat = 1'b1;
          if (last_beat) begin
            flush   = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge DDRAM_CLK or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      word_ptr <= '0;
      beat_cnt <= '0;
      cur_len  <= '0;
      pend     <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        beat_cnt <= '0;
        cur_len  <= burst_len;
      end else if (beat) begin
        beat_cnt <= beat_cnt + 8'd1;
      end
      if (accept)        pend <= 1'b0;
      else if (set_pend) pend <= 1'b1;
      if (flush)    word_ptr <= '0;
      else if (adv) word_ptr <= word_ptr + {17'b0, cur_len};
    end
  end

  // Words already buffered belong to the abandoned frame once a restart is pending.
  assign avail = !fifo_empty && (state != DRAIN) && !pend;
  assign pop   = pix_req && avail && (sub == 2'd3);

  always_ff @(posedge DDRAM_CLK or posedge reset) begin
    if (reset) begin
      pix_valid <= 1'b0;
      pix_data  <= '0;
      sub       <= '0;
      underflow <= 1'b0;
    end else begin
      pix_valid <= pix_req;
      if (pix_req) begin
        if (avail) begin
          pix_data <= fifo_dout[{sub, 4'b0000} +: 16];
          sub      <= sub + 2'd1;
        end else begin
          pix_data  <= '0;
          underflow <= 1'b1;
        end
      end
      if (flush) begin
        sub       <= '0;
        underflow <= 1'b0;
      end
    end
  end

  assign DDRAM_RD       = rd;
  assign DDRAM_BURSTCNT = burst_len;
  assign DDRAM_ADDR     = {DDRAM_REGION, BASE_WORD + word_ptr};
  assign DDRAM_WE       = 1'b0;
  assign DDRAM_BE       = '1;
  assign DDRAM_DIN      = '0;

endmodule

// File: tb/tb_ddram_fb_reader.sv
// Bench for ddram_fb_reader: memory responder plus word-queue reference model.
module tb_ddram_fb_reader;
  import ddram_pkg::*;

  localparam int unsigned FW    = 18;
  localparam int unsigned BL    = 8;
  localparam int unsigned DEPTH = 16;
  localparam logic [24:0] BASE_W    = 25'h0040000;
  localparam logic [28:0] BASE_ADDR = 29'h06040000;

  logic        DDRAM_CLK = 1'b0;
  logic        reset = 1'b1;
  logic        DDRAM_BUSY = 1'b0;
  logic [7:0]  DDRAM_BURSTCNT;
  logic [28:0] DDRAM_ADDR;
  logic [63:0] DDRAM_DOUT = '0;
  logic        DDRAM_DOUT_READY = 1'b0;
  logic        DDRAM_RD;
  logic        DDRAM_WE;
  logic [7:0]  DDRAM_BE;
  logic [63:0] DDRAM_DIN;
  logic        frame_start = 1'b0;
  logic        pix_req = 1'b0;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        underflow;

  always #5 DDRAM_CLK = ~DDRAM_CLK;

  ddram_fb_reader #(
    .FB_BASE     (27'h0200000),
    .FRAME_WORDS (FW),
    .BURST       (BL),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .DDRAM_CLK        (DDRAM_CLK),
    .reset            (reset),
    .DDRAM_BUSY       (DDRAM_BUSY),
    .DDRAM_BURSTCNT   (DDRAM_BURSTCNT),
    .DDRAM_ADDR       (DDRAM_ADDR),
    .DDRAM_DOUT       (DDRAM_DOUT),
    .DDRAM_DOUT_READY (DDRAM_DOUT_READY),
    .DDRAM_RD         (DDRAM_RD),
    .DDRAM_WE         (DDRAM_WE),
    .DDRAM_BE         (DDRAM_BE),
    .DDRAM_DIN        (DDRAM_DIN),
    .frame_start      (frame_start),
    .pix_req          (pix_req),
    .pix_data         (pix_data),
    .pix_valid        (pix_valid),
    .underflow        (underflow)
  );

  int unsigned checks = 0;
  int unsigned failures = 0;

  // Reference model: words the reader should hold, in frame order.
  ddr_word_t   q[$];
  int unsigned sub_m = 0;
  int unsigned outstanding = 0;
  int unsigned cmd_word = 0;
  int unsigned cmds_frame = 0;
  int unsigned n_acc = 0;
  int unsigned beat_pct = 100;
  bit          fsp = 1'b0;
  logic [24:0] beat_addr = '0;
  bit          exp_valid = 1'b0;
  bit          exp_uf = 1'b0;
  logic [15:0] exp_data = '0;
  bit          prev_hold = 1'b0;
  logic [28:0] held_addr = '0;
  logic [7:0]  held_len = '0;
  logic [28:0] last_acc_addr = '0;
  logic [31:0] salt = 32'h0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic ddr_word_t memword(input logic [24:0] a);
    if (a == BASE_W) return 64'h4444_3333_2222_1111;
    return {salt ^ {7'b0, a}, {a[15:0], ~a[15:0]} ^ ~salt};
  endfunction

  // One clock: check last edge's outputs, drive inputs, predict the next edge.
  task automatic step(input bit pr, input bit fs, input bit bz, input bit stray);
    bit          beat;
    bit          acc;
    ddr_word_t   w;
    int unsigned exp_len;
    chk("pix_valid", pix_valid, exp_valid);
    if (exp_valid) chk("pix_data", pix_data, exp_data);
    chk("underflow", underflow, exp_uf);
    if (DDRAM_RD) begin
      chk("single_outstanding", outstanding, 0);
      chk("rd_in_frame", cmd_word < FW, 1);
    end
    if (prev_hold) begin
      chk("rd_held", DDRAM_RD, 1);
      chk("addr_stable", DDRAM_ADDR, held_addr);
      chk("len_stable", DDRAM_BURSTCNT, held_len);
    end

    beat = stray || (outstanding > 0 && $urandom_range(99) < beat_pct);
    frame_start      = fs;
    pix_req          = pr;
    DDRAM_BUSY       = bz;
    DDRAM_DOUT_READY = beat;
    DDRAM_DOUT       = (outstanding > 0) ? memword(beat_addr) : {$urandom, $urandom};

    acc       = DDRAM_RD && !bz;
    prev_hold = DDRAM_RD && bz;
    held_addr = DDRAM_ADDR;
    held_len  = DDRAM_BURSTCNT;

    exp_valid = pr;
    if (pr) begin
      if (q.size() > 0 && !fsp) begin
        w        = q[0];
        exp_data = w[sub_m*16 +: 16];
        if (sub_m == 3) begin
          void'(q.pop_front());
          sub_m = 0;
        end else begin
          sub_m++;
        end
      end else begin
        exp_data = '0;
        exp_uf   = 1'b1;
      end
    end
    if (fs) fsp = 1'b1;
    if (beat && outstanding > 0) begin
      if (!fsp) q.push_back(memword(beat_addr));
      beat_addr++;
      outstanding--;
    end
    if (acc) begin
      exp_len = (FW - cmd_word < BL) ? FW - cmd_word : BL;
      chk("cmd_addr", DDRAM_ADDR, {4'b0011, BASE_W + 25'(cmd_word)});
      chk("cmd_len", DDRAM_BURSTCNT, exp_len);
      chk("free_slots", q.size() <= DEPTH - BL, 1);
      last_acc_addr = DDRAM_ADDR;
      n_acc++;
      cmds_frame++;
      outstanding = DDRAM_BURSTCNT;
      beat_addr   = DDRAM_ADDR[24:0];
      cmd_word   += DDRAM_BURSTCNT;
    end
    if (fsp && outstanding == 0 && !(DDRAM_RD && bz)) begin
      q.delete();
      sub_m      = 0;
      exp_uf     = 1'b0;
      cmd_word   = 0;
      cmds_frame = 0;
      fsp        = 1'b0;
    end
    @(posedge DDRAM_CLK);
    @(negedge DDRAM_CLK);
  endtask

  task automatic do_reset();
    reset            = 1'b1;
    frame_start      = 1'b0;
    pix_req          = 1'b0;
    DDRAM_BUSY       = 1'b0;
    DDRAM_DOUT_READY = 1'b0;
    #1;
    chk("rst_rd", DDRAM_RD, 0);
    chk("rst_burstcnt", DDRAM_BURSTCNT, BL);
    chk("rst_addr", DDRAM_ADDR, BASE_ADDR);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_pix_data", pix_data, 0);
    chk("rst_underflow", underflow, 0);
    chk("tie_we", DDRAM_WE, 0);
    chk("tie_be", DDRAM_BE, 8'hFF);
    chk("tie_din", DDRAM_DIN, 0);
    q.delete();
    sub_m = 0; outstanding = 0; cmd_word = 0; cmds_frame = 0;
    fsp = 1'b0; exp_valid = 1'b0; exp_uf = 1'b0; prev_hold = 1'b0;
    repeat (2) @(negedge DDRAM_CLK);
    reset = 1'b0;
  endtask

  task automatic wait_acc();
    int unsigned n0;
    n0 = n_acc;
    for (int i = 0; i < 40 && n_acc == n0; i++) step(0, 0, 0, 0);
    chk("cmd_issued", n_acc != n0, 1);
  endtask

  initial begin
    logic [15:0] pv [4];
    pv[0] = 16'h1111; pv[1] = 16'h2222; pv[2] = 16'h3333; pv[3] = 16'h4444;
    salt = $urandom;

    @(negedge DDRAM_CLK);
    do_reset();
    step(0, 1, 0, 0);

    wait_acc();
    chk("first_addr", last_acc_addr, BASE_ADDR);

    // Hold BUSY across the second command for five cycles.
    for (int i = 0; i < 40 && !DDRAM_RD; i++) step(0, 0, 1, 0);
    chk("second_rd_seen", DDRAM_RD, 1);
    repeat (5) step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    chk("one_accept", n_acc, 2);
    for (int i = 0; i < 40 && outstanding > 0; i++) step(0, 0, 1, 0);

    for (int k = 0; k < 4; k++) begin
      step(1, 0, 1, 0);
      chk("unpack_valid", pix_valid, 1);
      chk("unpack_data", pix_data, pv[k]);
    end

    // Consume the whole frame, popping only while words are buffered.
    for (int i = 0; i < 600 && !(q.size() == 0 && outstanding == 0 && cmd_word >= FW && !DDRAM_RD); i++)
      step(q.size() > 0, 0, 0, 0);
    repeat (20) step(0, 0, 0, 0);
    chk("frame_cmds", cmds_frame, 3);
    chk("halt_rd", DDRAM_RD, 0);
    chk("no_uf_yet", underflow, 0);

    step(1, 0, 0, 0);
    chk("empty_valid", pix_valid, 1);
    chk("empty_data", pix_data, 0);
    chk("empty_uf", underflow, 1);
    repeat (3) step(0, 0, 0, 0);
    chk("uf_sticky", underflow, 1);

    // Restart three beats into a burst.
    step(0, 1, 0, 0);
    chk("uf_cleared", underflow, 0);
    wait_acc();
    for (int i = 0; i < 20 && outstanding > 5; i++) step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    chk("drain_uf", underflow, 1);
    for (int i = 0; i < 40 && fsp; i++) step(0, 0, 0, 0);
    chk("drain_done", fsp, 0);
    wait_acc();
    chk("restart_addr", last_acc_addr, BASE_ADDR);

    // Reset in the middle of a burst, then a stray data beat.
    step(0, 0, 0, 0);
    chk("mid_burst", outstanding > 0, 1);
    do_reset();
    step(0, 0, 1, 1);
    step(1, 0, 1, 0);
    chk("post_rst_uf", underflow, 1);
    step(0, 1, 0, 0);

    beat_pct = 70;
    for (int i = 0; i < 4000; i++)
      step($urandom_range(99) < 35, $urandom_range(199) == 0, $urandom_range(99) < 40, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
